// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
package rr_reg_arbiter_pkg;

   localparam int MAX_N = 8;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Callers cast the result down to their own requester count.
   function automatic logic [MAX_N-1:0] onehot(input int idx, input int n);
      logic [MAX_N-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_N; i++) r[i] = (i == idx) && (i < n);
      return r;
   endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Requester/register bus of the round-robin register arbiter.
interface rr_reg_arbiter_if #(
   parameter int N = 4,
   parameter int W = 8
);
   import rr_reg_arbiter_pkg::*;

   localparam int PW = (N > 1) ? clog2(N) : 1;

   logic [N-1:0]   req;
   logic [N-1:0]   lock;
   logic [N*W-1:0] din;
   logic [N-1:0]   gnt;
   logic [W-1:0]   q;
   logic           qv;
   logic [PW-1:0]  owner;
   logic           locked;

   modport master (
      output req, lock, din,
      input  gnt, q, qv, owner, locked
   );

   modport slave (
      input  req, lock, din,
      output gnt, q, qv, owner, locked
   );

endinterface

// File: rtl/rr_reg_arbiter_pick.sv
// Rotating picker: first eligible requester at or after i_ptr, wrapping mod N.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   input  logic [N-1:0]  i_mask,
   output logic          o_found,
   output logic [PW-1:0] o_idx
);

   localparam logic [PW:0] NV = (PW+1)'(N);

   logic [N-1:0]  w_elig;
   logic [N-1:0]  w_rot;
   logic [PW-1:0] w_off;
   logic [PW:0]   w_sum;

   assign w_elig = i_req & ~i_mask;
   // Rotation by doubling keeps every shift amount below N inside the window.
   assign w_rot  = N'({w_elig, w_elig} >> i_ptr);

   // Fixed priority on the rotated vector, lowest offset wins.
   always_comb begin
      o_found = 1'b0;
      w_off   = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            o_found = 1'b1;
            w_off   = PW'(j);
         end
      end
   end

   assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
   assign o_idx = (w_sum >= NV) ? PW'(w_sum - NV) : PW'(w_sum);

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter owning one shared enabled register, with per-requester lock.
//
//  state  | meaning
//  ARB    | pick a new winner each cycle starting at ptr
//  LOCKED | owner keeps the register while req[owner] & lock[owner]
module rr_reg_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input logic              clk,
   input logic              aClr,
   rr_reg_arbiter_if.slave  bus
);
   import rr_reg_arbiter_pkg::*;

   localparam int            PW   = (N > 1) ? clog2(N) : 1;
   localparam logic [PW-1:0] PMAX = PW'(N - 1);

   arb_state_e    r_state;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_owner;
   logic [N-1:0]  r_gnt;
   logic [W-1:0]  r_q;
   logic          r_qv;

   logic [N-1:0]  w_oh_owner;
   logic [N-1:0]  w_oh_idx;
   logic [N-1:0]  w_mask;
   logic [N-1:0]  w_gnt_nxt;
   logic [PW-1:0] w_pick_ptr;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_win;
   logic [W-1:0]  w_din_sel;
   logic          w_in_lock;
   logic          w_found;
   logic          w_hold;
   logic          w_win_lock;
   logic          w_en;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] v);
      return (v == PMAX) ? '0 : v + 1'b1;
   endfunction

   assign w_in_lock  = (r_state == LOCKED);
   assign w_oh_owner = N'(onehot(int'(r_owner), N));
   assign w_hold     = w_in_lock && |(bus.req & bus.lock & w_oh_owner);
   // On release the old owner sits out the same-cycle re-arbitration.
   assign w_pick_ptr = w_in_lock ? f_inc(r_owner) : r_ptr;
   assign w_mask     = w_in_lock ? w_oh_owner : '0;

   rr_pick #(.N(N), .PW(PW)) u_pick (
      .i_req   (bus.req),
      .i_ptr   (w_pick_ptr),
      .i_mask  (w_mask),
      .o_found (w_found),
      .o_idx   (w_idx)
   );

   assign w_oh_idx   = N'(onehot(int'(w_idx), N));
   assign w_win_lock = |(bus.lock & w_oh_idx);
   assign w_win      = w_hold ? r_owner : w_idx;
   assign w_en       = w_hold | w_found;
   assign w_gnt_nxt  = N'(onehot(int'(w_win), N));

   // Data mux for the winning requester.
   always_comb begin
      w_din_sel = '0;
      for (int i = 0; i < N; i++) begin
         if (w_win == PW'(i)) w_din_sel = bus.din[i*W +: W];
      end
   end

   // Arbitration FSM with pointer, owner, grant and valid registers.
   always_ff @(posedge clk or posedge aClr) begin
      if (aClr) begin
         r_state <= ARB;
         r_ptr   <= '0;
         r_owner <= '0;
         r_gnt   <= '0;
         r_qv    <= 1'b0;
      end else begin
         r_gnt <= w_en ? w_gnt_nxt : '0;
         if (w_hold) begin
            r_state <= LOCKED;
         end else begin
            if (w_found) begin
               r_owner <= w_idx;
               r_qv    <= 1'b1;
            end
            if (w_found && w_win_lock) begin
               r_state <= LOCKED;
               r_ptr   <= w_pick_ptr;
            end else begin
               r_state <= ARB;
               r_ptr   <= w_found ? f_inc(w_idx) : w_pick_ptr;
            end
         end
      end
   end

   // Shared register, loaded only through its enable.
   always_ff @(posedge clk or posedge aClr) begin
      if (aClr)      r_q <= '0;
      else if (w_en) r_q <= w_din_sel;
   end

   assign bus.gnt    = r_gnt;
   assign bus.q      = r_q;
   assign bus.qv     = r_qv;
   assign bus.owner  = r_owner;
   assign bus.locked = w_in_lock;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Scoreboard bench for rr_reg_arbiter (N=4, W=8).
module tb_rr_reg_arbiter;

   typedef struct packed {
      logic [3:0] gnt;
      logic [7:0] q;
      logic       qv;
      logic       locked;
   } exp_t;

   logic clk = 1'b0;
   logic aClr;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   rr_reg_arbiter_if #(.N(4), .W(8)) bus ();

   rr_reg_arbiter #(.N(4), .W(8)) dut (
      .clk  (clk),
      .aClr (aClr),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_din_default();
      for (int i = 0; i < 4; i++) bus.din[i*8 +: 8] = 8'h10 + 8'(i);
   endtask

   task automatic do_reset();
      aClr     = 1'b1;
      bus.req  = '0;
      bus.lock = '0;
      set_din_default();
      @(posedge clk);
      @(negedge clk);
      aClr = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      aClr     = 1'b1;
      bus.req  = 4'hF;
      bus.lock = '0;
      set_din_default();
      tick();
      checks++;
      if ({bus.gnt, bus.q, bus.qv, bus.locked} !== 14'h0)
         $display("FAIL reset_state: got gnt=%b q=%h qv=%b locked=%b, want all zero",
                  bus.gnt, bus.q, bus.qv, bus.locked);
      if ({bus.gnt, bus.q, bus.qv, bus.locked} !== 14'h0) errors++;
      @(negedge clk);
      aClr = 1'b0;
      #1;
      checks++;
      if (bus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release_no_grant: got gnt=%b, want 0000", bus.gnt);
      end
      sb.push_back('{gnt: 4'b0001, q: 8'h10, qv: 1'b1, locked: 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.q, bus.qv, bus.locked} !== e) begin
         errors++;
         $display("FAIL reset_first_grant: got gnt=%b q=%h qv=%b locked=%b, want gnt=%b q=%h qv=%b locked=%b",
                  bus.gnt, bus.q, bus.qv, bus.locked, e.gnt, e.q, e.qv, e.locked);
      end
   endtask

   task automatic test_rotation();
      exp_t e;
      do_reset();
      bus.req = 4'hF;
      for (int i = 0; i < 8; i++) begin
         sb.push_back('{gnt: 4'b0001 << (i % 4), q: 8'h10 + 8'(i % 4), qv: 1'b1, locked: 1'b0});
         tick();
         e = sb.pop_front();
         checks++;
         if ({bus.gnt, bus.q, bus.qv, bus.locked} !== e) begin
            errors++;
            $display("FAIL rotation step %0d: got gnt=%b q=%h qv=%b locked=%b, want gnt=%b q=%h qv=%b locked=%b",
                     i, bus.gnt, bus.q, bus.qv, bus.locked, e.gnt, e.q, e.qv, e.locked);
         end
      end
   endtask

   // Continues from rotation (ptr back at 0): walk ptr to 3, then skip/wrap.
   task automatic test_skip_wrap();
      exp_t       e;
      logic [3:0] rq [5] = '{4'hF, 4'hF, 4'hF, 4'b0101, 4'b0100};
      logic [3:0] eg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0100};
      logic [7:0] eq [5] = '{8'h10, 8'h11, 8'h12, 8'h10, 8'h12};
      for (int i = 0; i < 5; i++) begin
         bus.req = rq[i];
         sb.push_back('{gnt: eg[i], q: eq[i], qv: 1'b1, locked: 1'b0});
         tick();
         e = sb.pop_front();
         checks++;
         if ({bus.gnt, bus.q, bus.qv, bus.locked} !== e) begin
            errors++;
            $display("FAIL skip_wrap step %0d: got gnt=%b q=%h qv=%b locked=%b, want gnt=%b q=%h qv=%b locked=%b",
                     i, bus.gnt, bus.q, bus.qv, bus.locked, e.gnt, e.q, e.qv, e.locked);
         end
      end
   endtask

   task automatic test_lock_burst();
      exp_t       e;
      logic [3:0] rq [6] = '{4'b0001, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
      logic [3:0] lk [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
      logic [7:0] d1 [6] = '{8'h11, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
      logic [3:0] eg [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
      logic [7:0] eq [6] = '{8'h10, 8'h20, 8'h21, 8'h22, 8'h23, 8'h12};
      logic       el [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         bus.req        = rq[i];
         bus.lock       = lk[i];
         bus.din[15:8]  = d1[i];
         sb.push_back('{gnt: eg[i], q: eq[i], qv: 1'b1, locked: el[i]});
         tick();
         e = sb.pop_front();
         checks++;
         if ({bus.gnt, bus.q, bus.qv, bus.locked} !== e) begin
            errors++;
            $display("FAIL lock_burst step %0d: got gnt=%b q=%h qv=%b locked=%b, want gnt=%b q=%h qv=%b locked=%b",
                     i, bus.gnt, bus.q, bus.qv, bus.locked, e.gnt, e.q, e.qv, e.locked);
         end
      end
      set_din_default();
   endtask

   // Releasing owner is the only requester: no pick in the release cycle.
   task automatic test_release_exclude();
      exp_t       e;
      logic [3:0] lk [3] = '{4'b0001, 4'b0000, 4'b0000};
      logic [3:0] eg [3] = '{4'b0001, 4'b0000, 4'b0001};
      logic       el [3] = '{1'b1, 1'b0, 1'b0};
      do_reset();
      bus.req = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         bus.lock = lk[i];
         sb.push_back('{gnt: eg[i], q: 8'h10, qv: 1'b1, locked: el[i]});
         tick();
         e = sb.pop_front();
         checks++;
         if ({bus.gnt, bus.q, bus.qv, bus.locked} !== e) begin
            errors++;
            $display("FAIL release_exclude step %0d: got gnt=%b q=%h qv=%b locked=%b, want gnt=%b q=%h qv=%b locked=%b",
                     i, bus.gnt, bus.q, bus.qv, bus.locked, e.gnt, e.q, e.qv, e.locked);
         end
      end
   endtask

   task automatic test_idle_hold();
      exp_t e;
      bus.din[7:0] = 8'hA5;
      bus.lock     = '0;
      for (int i = 0; i < 6; i++) begin
         bus.req = (i == 0) ? 4'b0001 : 4'b0000;
         sb.push_back('{gnt: (i == 0) ? 4'b0001 : 4'b0000, q: 8'hA5, qv: 1'b1, locked: 1'b0});
         tick();
         e = sb.pop_front();
         checks++;
         if ({bus.gnt, bus.q, bus.qv, bus.locked} !== e) begin
            errors++;
            $display("FAIL idle_hold step %0d: got gnt=%b q=%h qv=%b locked=%b, want gnt=%b q=%h qv=%b locked=%b",
                     i, bus.gnt, bus.q, bus.qv, bus.locked, e.gnt, e.q, e.qv, e.locked);
         end
      end
      set_din_default();
   endtask

   // ptr is 1 on entry, so requester 1 takes the lock.
   task automatic test_async_reset_locked();
      exp_t e;
      bus.req  = 4'hF;
      bus.lock = 4'hF;
      for (int i = 0; i < 2; i++) begin
         sb.push_back('{gnt: 4'b0010, q: 8'h11, qv: 1'b1, locked: 1'b1});
         tick();
         e = sb.pop_front();
         checks++;
         if ({bus.gnt, bus.q, bus.qv, bus.locked} !== e) begin
            errors++;
            $display("FAIL async_lock_setup step %0d: got gnt=%b q=%h qv=%b locked=%b, want gnt=%b q=%h qv=%b locked=%b",
                     i, bus.gnt, bus.q, bus.qv, bus.locked, e.gnt, e.q, e.qv, e.locked);
         end
      end
      @(negedge clk);
      aClr = 1'b1;
      #1;
      checks++;
      if ({bus.gnt, bus.q, bus.qv, bus.locked} !== 14'h0) begin
         errors++;
         $display("FAIL async_clear_immediate: got gnt=%b q=%h qv=%b locked=%b, want all zero",
                  bus.gnt, bus.q, bus.qv, bus.locked);
      end
      @(posedge clk);
      @(negedge clk);
      aClr     = 1'b0;
      bus.lock = '0;
      bus.req  = 4'hF;
      sb.push_back('{gnt: 4'b0001, q: 8'h10, qv: 1'b1, locked: 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({bus.gnt, bus.q, bus.qv, bus.locked} !== e) begin
         errors++;
         $display("FAIL async_after_release: got gnt=%b q=%h qv=%b locked=%b, want gnt=%b q=%h qv=%b locked=%b",
                  bus.gnt, bus.q, bus.qv, bus.locked, e.gnt, e.q, e.qv, e.locked);
      end
   endtask

   initial begin
      aClr     = 1'b1;
      bus.req  = '0;
      bus.lock = '0;
      set_din_default();
      test_reset();
      test_rotation();
      test_skip_wrap();
      test_lock_burst();
      test_release_exclude();
      test_idle_hold();
      test_async_reset_locked();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
